// File: rtl/watch_pkg.sv
// watch_pkg: shared field geometry, limits, offsets and FSM encoding for the watch timer
package watch_pkg;
  localparam int FIELD_WIDTH = 6;
  localparam int DATA_WIDTH = 18;
  localparam int MAX_SEC = 59;
  localparam int MAX_MIN = 59;
  localparam int MAX_HOUR = 23;
  localparam int SEC_LSB = 0;
  localparam int MIN_LSB = 6;
  localparam int HOUR_LSB = 12;
  typedef enum logic {RUN = 1'b0, SET = 1'b1} state_t;
endpackage

// File: rtl/watch_timer_mod_counter.sv
// mod_counter: one modulo time field with load > clear > inc priority and wrap carry
module mod_counter
  import watch_pkg::*;
#(
  parameter int modulus = 60,
  parameter int width = FIELD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  input  logic             load,
  input  logic [width-1:0] load_val,
  output logic [width-1:0] value,
  output logic             carry_out
);
  logic at_max;
  assign at_max = value == width'(modulus - 1);
  assign carry_out = inc && at_max;
  // field register: load wins over clear, clear over increment
  always_ff @(posedge clock or negedge reset)
    if (!reset) value <= '0;
    else if (load) value <= load_val;
    else if (clear) value <= '0;
    else if (inc) value <= at_max ? '0 : value + 1'b1;
endmodule

// File: rtl/watch_timer.sv
// watch_timer: 1 Hz hh:mm:ss keeper with set mode and checked load; chime built only with HOUR_CHIME_EN
module watch_timer
  import watch_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int field_width = FIELD_WIDTH,
  parameter int second_cnt = 52428800,
  parameter int counter_width = 26
) (
  input  logic                  reset,
  input  logic                  clock,
  input  logic                  set_mode,
  input  logic                  inc_hour,
  input  logic                  inc_min,
  input  logic                  clear_sec,
  input  logic                  load,
  input  logic [data_width-1:0] load_data,
  output logic [data_width-1:0] timer_data,
  output logic                  second_tick,
  output logic                  load_err,
  output logic                  chime
);
  state_t state, state_next;
  logic [counter_width-1:0] prescaler;
  logic [field_width-1:0] sec, min, hour, ld_sec, ld_min, ld_hour;
  logic run, edit, terminal, load_ok, tick;
  logic sec_carry, min_carry, day_carry_unused;
  assign ld_sec = load_data[SEC_LSB +: field_width];
  assign ld_min = load_data[MIN_LSB +: field_width];
  assign ld_hour = load_data[HOUR_LSB +: field_width];
  assign timer_data = {hour, min, sec};
  // mode register
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= RUN;
    else state <= state_next;
  // mode follows the set_mode level
  always_comb state_next = set_mode ? SET : RUN;
  // mode-dependent enables; an accepted load swallows a coincident tick
  always_comb begin
    run = state == RUN;
    edit = state == SET;
    terminal = run && prescaler == counter_width'(second_cnt - 1);
    load_ok = load && ld_sec <= field_width'(MAX_SEC) && ld_min <= field_width'(MAX_MIN)
              && ld_hour <= field_width'(MAX_HOUR);
    tick = terminal && !load_ok;
  end
  // prescaler runs only in RUN and parks at zero while setting
  always_ff @(posedge clock or negedge reset)
    if (!reset) prescaler <= '0;
    else if (!run) prescaler <= '0;
    else prescaler <= terminal ? '0 : prescaler + 1'b1;
  // status pulses registered alongside the field update
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      second_tick <= 1'b0;
      load_err <= 1'b0;
    end else begin
      second_tick <= tick;
      load_err <= load && !load_ok;
    end
  mod_counter #(.modulus(MAX_SEC + 1), .width(field_width)) u_sec (
    .clock(clock), .reset(reset), .inc(tick), .clear(edit && clear_sec), .load(load_ok),
    .load_val(ld_sec), .value(sec), .carry_out(sec_carry)
  );
  mod_counter #(.modulus(MAX_MIN + 1), .width(field_width)) u_min (
    .clock(clock), .reset(reset), .inc(run ? sec_carry : edit && inc_min), .clear(1'b0),
    .load(load_ok), .load_val(ld_min), .value(min), .carry_out(min_carry)
  );
  mod_counter #(.modulus(MAX_HOUR + 1), .width(field_width)) u_hour (
    .clock(clock), .reset(reset), .inc(run ? min_carry : edit && inc_hour), .clear(1'b0),
    .load(load_ok), .load_val(ld_hour), .value(hour), .carry_out(day_carry_unused)
  );
`ifdef HOUR_CHIME_EN
  // chime only when a running tick rolls mm:ss over the hour
  always_ff @(posedge clock or negedge reset)
    if (!reset) chime <= 1'b0;
    else chime <= min_carry && run;
`else
  assign chime = 1'b0;
`endif
endmodule
